serialiser_unit_cell: RTL and testbench

SERIALISER_UNIT_CELL -- requirements
Module: serialiser_unit_cell

---
 rtl/serialiser_unit_cell.sv | 111 +++++++++++
 tb/tb_serialiser_unit_cell.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serialiser_unit_cell.sv
// Fixed-frame parallel-to-serial cell: eight 32-bit words, LSB first,
// with READY framing, a one-cycle DONE pulse and synchronous abort.
module serialiser_unit_cell (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic        ABORT,
    input  logic [31:0] PAR_OUT1,
    input  logic [31:0] PAR_OUT2,
    input  logic [31:0] PAR_OUT3,
    input  logic [31:0] PAR_OUT4,
    input  logic [31:0] PAR_OUT5,
    input  logic [31:0] PAR_OUT6,
    input  logic [31:0] PAR_OUT7,
    input  logic [31:0] PAR_OUT8,
    output logic        SERIAL_OUT,
    output logic        READY,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  WORD_COUNT,
    output logic [4:0]  BIT_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [255:0] shadow_q, shadow_d;
    logic [7:0]   pos_q, pos_d;
    logic [7:0]   pos_nxt;
    logic         serial_q, serial_d;
    logic         ready_q, ready_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // Frame position {word, bit} doubles as the flat shadow bit index.
    assign pos_nxt = pos_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pos_d    = 8'd0;
        serial_d = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_SHIFT: begin
                    if (pos_q == 8'hFF) begin
                        state_d = S_DONE;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        pos_d    = pos_nxt;
                        serial_d = shadow_q[pos_nxt];
                        ready_d  = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                default: begin
                    if (LOAD) begin
                        state_d  = S_SHIFT;
                        shadow_d = {PAR_OUT8, PAR_OUT7,
                                    PAR_OUT6, PAR_OUT5,
                                    PAR_OUT4, PAR_OUT3,
                                    PAR_OUT2, PAR_OUT1};
                        serial_d = PAR_OUT1[0];
                        ready_d  = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            pos_q    <= 8'd0;
            serial_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pos_q    <= pos_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign SERIAL_OUT = serial_q;
    assign READY      = ready_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign WORD_COUNT = pos_q[7:5];
    assign BIT_COUNT  = pos_q[4:0];

endmodule

// File: tb/tb_serialiser_unit_cell.sv
// Scoreboard bench for serialiser_unit_cell with a loopback deserialiser
// model that reassembles each frame and checks it on DONE.
module tb_serialiser_unit_cell;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        LOAD = 1'b0;
    logic        ABORT = 1'b0;
    logic [31:0] par [1:8];
    logic        SERIAL_OUT, READY, BUSY, DONE;
    logic [2:0]  WORD_COUNT;
    logic [4:0]  BIT_COUNT;

    typedef struct packed {
        logic       s;
        logic [2:0] w;
        logic [4:0] b;
    } bit_t;

    bit_t         exp_q[$];
    logic [255:0] exp_w[$];
    logic [255:0] deser = '0;
    int           total = 0;
    int           bad = 0;

    serialiser_unit_cell dut (
        .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .ABORT(ABORT),
        .PAR_OUT1(par[1]), .PAR_OUT2(par[2]),
        .PAR_OUT3(par[3]), .PAR_OUT4(par[4]),
        .PAR_OUT5(par[5]), .PAR_OUT6(par[6]),
        .PAR_OUT7(par[7]), .PAR_OUT8(par[8]),
        .SERIAL_OUT(SERIAL_OUT), .READY(READY), .BUSY(BUSY),
        .DONE(DONE), .WORD_COUNT(WORD_COUNT), .BIT_COUNT(BIT_COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string nm, logic [255:0] act,
                                logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void push_frame();
        logic [255:0] f;
        logic [7:0]   p8;
        f = {par[8], par[7], par[6], par[5],
             par[4], par[3], par[2], par[1]};
        for (int i = 0; i < 256; i++) begin
            p8 = 8'(i);
            exp_q.push_back(bit_t'{f[i], p8[7:5], p8[4:0]});
        end
        exp_w.push_back(f);
    endfunction

    // Monitor: bit stream and deserialised words against the queues.
    always @(negedge CLK) begin
        bit_t e;
        if (READY === 1'b1) begin
            deser = {SERIAL_OUT, deser[255:1]};
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_bit",
                    {BUSY, SERIAL_OUT, WORD_COUNT, BIT_COUNT},
                    {1'b1, e});
            end
        end
        if (DONE === 1'b1) begin
            if (exp_w.size() == 0) chk("unexpected_done", 1, 0);
            else chk("deser_words", deser, exp_w.pop_front());
        end
    end

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic check_idle(string nm);
        chk(nm, {SERIAL_OUT, READY, BUSY, DONE,
                 WORD_COUNT, BIT_COUNT}, 0);
    endtask

    task automatic wait_done(string nm, output int n);
        n = 0;
        while (DONE !== 1'b1 && n < 400) begin
            n++;
            cyc();
        end
        if (n >= 400) chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic start_frame();
        push_frame();
        LOAD = 1'b1;
        cyc();
        LOAD = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 1; i <= 8; i++) par[i] = 32'hA5A5_0000 + 32'(i);
        #1 RESET = 1'b1;
        #1 check_idle("reset_async");
        repeat (2) cyc();
        check_idle("reset_hold");

        // Single frame, LOAD on the first edge after reset release
        RESET = 1'b0;
        start_frame();
        chk("first_bit", {READY, BUSY, SERIAL_OUT, WORD_COUNT, BIT_COUNT},
            {1'b1, 1'b1, 1'b1, 3'd0, 5'd0});
        n = 0;
        while (READY === 1'b1 && n < 300) begin
            n++;
            cyc();
        end
        chk("ready_len", n, 256);
        chk("done_state", {READY, BUSY, DONE, SERIAL_OUT,
                           WORD_COUNT, BIT_COUNT},
            {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 5'd0});
        cyc();
        check_idle("idle_after_done");

        // Input change after capture and LOAD during SHIFT are ignored
        for (int i = 1; i <= 8; i++) par[i] = 32'h1234_5670 + 32'(i);
        start_frame();
        par[1] = 32'hFFFF_FFFF;
        repeat (99) cyc();
        for (int i = 1; i <= 8; i++) par[i] = 32'hDEAD_BEEF;
        LOAD = 1'b1;
        cyc();
        LOAD = 1'b0;
        wait_done("chg", n);
        chk("chg_done_at", n, 156);
        cyc();
        check_idle("chg_idle");

        // Back-to-back frames with LOAD held high
        for (int i = 1; i <= 8; i++) par[i] = 32'hC3C3_0000 | 32'(i * 17);
        push_frame();
        push_frame();
        push_frame();
        LOAD = 1'b1;
        cyc();
        wait_done("b2b1", n);
        chk("b2b_first_done", n, 256);
        chk("b2b_gap_low", READY, 0);
        cyc();
        chk("b2b_restart", {READY, WORD_COUNT, BIT_COUNT}, {1'b1, 8'd0});
        wait_done("b2b2", n);
        chk("b2b_period1", n + 1, 257);
        cyc();
        chk("b2b_restart2", READY, 1);
        wait_done("b2b3", n);
        chk("b2b_period2", n + 1, 257);
        LOAD = 1'b0;
        cyc();
        check_idle("b2b_stop");

        // Abort at word 3 bit 10
        for (int i = 1; i <= 8; i++) par[i] = 32'h5A5A_F000 + 32'(i);
        start_frame();
        n = 0;
        while (!(WORD_COUNT == 3'd3 && BIT_COUNT == 5'd10) && n < 300) begin
            n++;
            cyc();
        end
        chk("abort_reach", n, 106);
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        check_idle("abort_outputs");
        chk("abort_pending", exp_q.size(), 149);
        exp_q.delete();
        exp_w.delete();
        repeat (300) cyc();
        check_idle("abort_quiet");
        ABORT = 1'b1;
        LOAD = 1'b1;
        cyc();
        ABORT = 1'b0;
        LOAD = 1'b0;
        check_idle("abort_over_load");

        // Asynchronous reset mid-frame, then loopback frame
        for (int i = 1; i <= 8; i++) par[i] = 32'h1111_1111 * 32'(i);
        start_frame();
        repeat (40) cyc();
        #2 RESET = 1'b1;
        #1 check_idle("async_mid_frame");
        exp_q.delete();
        exp_w.delete();
        cyc();
        RESET = 1'b0;
        start_frame();
        chk("clean_first_bit", {READY, SERIAL_OUT, WORD_COUNT, BIT_COUNT},
            {1'b1, par[1][0], 3'd0, 5'd0});
        wait_done("loop", n);
        chk("loop_done_at", n, 256);
        cyc();
        check_idle("loop_idle");

        chk("scoreboard_drained", exp_q.size() + exp_w.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
